// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall patterns, FSM state encodings and parameter defaults
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    CTRL_RUN    = 2'd0,
    CTRL_FLUSH  = 2'd1,
    CTRL_HALTED = 2'd2
  } ctrl_state_e;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;
  localparam int WDOG_DEF  = 64;
  localparam int CNT_W_DEF = 16;
  function automatic int wdog_w(input int limit);
    return $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that stops at MAX and flags it
module sat_counter #(
  parameter int W = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         max_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign max_o = cnt_q == MAX;
  assign cnt_o = cnt_q;
  // clear wins over increment; increment stops at MAX
  always_comb cnt_d = clr_i ? '0 : (inc_i && !max_o) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer driving stage stalls, flush/redirect, debug halt and watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WDOG_LIMIT = WDOG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             excp_req,
  input  logic [31:0]      excp_pc,
  input  logic             halt_req,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             halt_ack_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);
  localparam int WD_W = wdog_w(WDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(WDOG_LIMIT - 1);
  ctrl_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        flush_q, ack_q;
  logic        wd_clr;
  logic [WD_W-1:0] wd_cnt;
  // next state, stall decode and redirect target selection
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    new_pc_d  = new_pc_q;
    stall_o   = STALL_NONE;
    unique case (state_q)
      CTRL_RUN:
        if (excp_req) begin
          stall_o  = STALL_ALL;
          new_pc_d = excp_pc;
          state_d  = CTRL_FLUSH;
        end else if (stallreq_ex) stall_o = STALL_EX;
        else if (stallreq_id) stall_o = STALL_ID;
        else if (halt_req) begin
          stall_o = STALL_ALL;
          state_d = CTRL_HALTED;
        end
      CTRL_FLUSH: state_d = CTRL_RUN;
      CTRL_HALTED: begin
        stall_o = STALL_ALL;
        if (excp_req) begin
          pend_d    = 1'b1;
          pend_pc_d = excp_pc;
        end
        if (!halt_req) begin
          state_d  = pend_d ? CTRL_FLUSH : CTRL_RUN;
          new_pc_d = pend_d ? pend_pc_d : new_pc_q;
          pend_d   = 1'b0;
        end
      end
      default: state_d = CTRL_RUN;
    endcase
  end
  // state and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CTRL_RUN;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      new_pc_q  <= '0;
      flush_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      new_pc_q  <= new_pc_d;
      flush_q   <= state_d == CTRL_FLUSH;
      ack_q     <= state_d == CTRL_HALTED;
    end
  end
  assign flush_o    = flush_q;
  assign new_pc_o   = new_pc_q;
  assign halt_ack_o = ack_q;
  assign wd_clr     = !(state_q == CTRL_RUN && stallreq_ex);
  assign timeout_o  = !wd_clr && wd_cnt == WD_FIRE;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (stall_o[2]),
    .cnt_o (stall_cnt_o),
    .max_o ()
  );
  sat_counter #(.W(WD_W), .MAX(WD_MAX)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wd_clr),
    .inc_i (1'b1),
    .cnt_o (wd_cnt),
    .max_o ()
  );
endmodule
